// File: rtl/axi_pkg.sv
// Shared AXI read-channel constants, scheduler state encoding and requester indices.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [3:0] CACHE_NONE  = 4'b0000;
  localparam logic [2:0] PROT_NONE   = 3'b000;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  localparam logic [3:0] ARID_I = 4'd0;
  localparam logic [3:0] ARID_D = 4'd1;
  localparam logic [3:0] ARID_U = 4'd2;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StAddr = 2'd1;
  localparam state_t StData = 2'd2;

  typedef logic [1:0] req_idx_t;
  localparam req_idx_t REQ_I = 2'd0;
  localparam req_idx_t REQ_D = 2'd1;
  localparam req_idx_t REQ_U = 2'd2;

  function automatic logic [3:0] req_arid(req_idx_t idx);
    case (idx)
      REQ_I:   return ARID_I;
      REQ_D:   return ARID_D;
      default: return ARID_U;
    endcase
  endfunction

endpackage

// File: rtl/axi_rd_sched_if.sv
// AXI read address/data channel between the scheduler (master) and the bus (slave).
interface axi_rd_sched_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin picker; priority starts just after the last grant.
module rr_arb3
  import axi_pkg::*;
(
  input  logic [2:0] req_i,
  input  req_idx_t   last_grant_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = 3'b000;
    unique case (last_grant_i)
      REQ_I: begin
        if      (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      REQ_D: begin
        if      (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/axi_rd_sched.sv
// Shares one AXI read channel between I-cache, D-cache and uncached requesters,
// one burst outstanding, with per-beat length/response/id checking.
module axi_rd_sched
  import axi_pkg::*;
(
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [31:0]    i_araddr,
  input  logic [7:0]     i_arlen,
  input  logic [2:0]     i_arsize,
  input  logic           i_arvalid,
  output logic           i_arready,
  output logic [31:0]    i_rdata,
  output logic           i_rlast,
  output logic           i_rvalid,
  input  logic           i_rready,
  input  logic [31:0]    d_araddr,
  input  logic [7:0]     d_arlen,
  input  logic [2:0]     d_arsize,
  input  logic           d_arvalid,
  output logic           d_arready,
  output logic [31:0]    d_rdata,
  output logic           d_rlast,
  output logic           d_rvalid,
  input  logic           d_rready,
  input  logic [31:0]    u_araddr,
  input  logic [7:0]     u_arlen,
  input  logic [2:0]     u_arsize,
  input  logic           u_arvalid,
  output logic           u_arready,
  output logic [31:0]    u_rdata,
  output logic           u_rlast,
  output logic           u_rvalid,
  input  logic           u_rready,
  axi_rd_sched_if.master axi,
  output logic           rd_err
);

  state_t      state_q, state_d;
  req_idx_t    owner_q, last_grant_q, win_idx;
  logic [31:0] araddr_q, win_addr;
  logic [7:0]  arlen_q, win_len, beat_cnt_q;
  logic [2:0]  arsize_q, win_size, req, gnt;
  logic [3:0]  arid_q;
  logic        rd_err_q, owner_rready, in_data, grant, ar_hs, beat, beat_err;

  assign req = {u_arvalid, d_arvalid, i_arvalid};

  rr_arb3 u_arb (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  always_comb begin
    win_idx  = REQ_I;
    win_addr = i_araddr;
    win_len  = i_arlen;
    win_size = i_arsize;
    unique case (gnt)
      3'b010: begin
        win_idx  = REQ_D;
        win_addr = d_araddr;
        win_len  = d_arlen;
        win_size = d_arsize;
      end
      3'b100: begin
        win_idx  = REQ_U;
        win_addr = u_araddr;
        win_len  = u_arlen;
        win_size = u_arsize;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_rready = i_rready;
    unique case (owner_q)
      REQ_D:   owner_rready = d_rready;
      REQ_U:   owner_rready = u_rready;
      default: owner_rready = i_rready;
    endcase
  end

  assign in_data = (state_q == StData);
  assign grant   = (state_q == StIdle) && (req != 3'b000);
  assign ar_hs   = (state_q == StAddr) && axi.arready;
  assign beat    = in_data && axi.rvalid && owner_rready;

  // Data is delivered regardless; a bad beat only raises the error pulse.
  assign beat_err = beat && ((axi.rlast && (beat_cnt_q != arlen_q)) ||
                             (!axi.rlast && (beat_cnt_q == arlen_q)) ||
                             (axi.rresp != RESP_OKAY) || (axi.rid != arid_q));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StAddr;
      StAddr:  if (axi.arready) state_d = StData;
      StData:  if (beat && axi.rlast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arid_q       <= '0;
      rd_err_q     <= 1'b0;
      last_grant_q <= REQ_U;
      owner_q      <= REQ_I;
      beat_cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_err_q <= beat_err;
      if (grant) begin
        araddr_q   <= win_addr;
        arlen_q    <= win_len;
        arsize_q   <= win_size;
        arid_q     <= req_arid(win_idx);
        owner_q    <= win_idx;
        beat_cnt_q <= '0;
      end
      if (ar_hs) last_grant_q <= owner_q;
      if (beat)  beat_cnt_q   <= beat_cnt_q + 8'd1;
    end
  end

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arvalid = (state_q == StAddr);
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = LOCK_NORMAL;
  assign axi.arcache = CACHE_NONE;
  assign axi.arprot  = PROT_NONE;
  assign axi.rready  = in_data && owner_rready;

  assign i_arready = ar_hs && (owner_q == REQ_I);
  assign d_arready = ar_hs && (owner_q == REQ_D);
  assign u_arready = ar_hs && (owner_q == REQ_U);

  assign i_rvalid = in_data && (owner_q == REQ_I) && axi.rvalid;
  assign d_rvalid = in_data && (owner_q == REQ_D) && axi.rvalid;
  assign u_rvalid = in_data && (owner_q == REQ_U) && axi.rvalid;
  assign i_rlast  = in_data && (owner_q == REQ_I) && axi.rlast;
  assign d_rlast  = in_data && (owner_q == REQ_D) && axi.rlast;
  assign u_rlast  = in_data && (owner_q == REQ_U) && axi.rlast;

  assign i_rdata = axi.rdata;
  assign d_rdata = axi.rdata;
  assign u_rdata = axi.rdata;

  assign rd_err = rd_err_q;

endmodule
